// File: rtl/dmem_arbiter_if.sv
// Requester-side handshake port and data_mem-side bus used by dmem_arbiter.
// The arbiter takes the slave end of each requester port and the master end of the memory bus.
interface dmem_port_if #(parameter int DATA_W = 64);
    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    logic              err;

    modport master (output req, we, addr, wdata, input rdata, ack, err);
    modport slave  (input req, we, addr, wdata, output rdata, ack, err);
endinterface

interface dmem_bus_if #(parameter int DATA_W = 64);
    logic [DATA_W-1:0] address;
    logic [DATA_W-1:0] wrt_data;
    logic [DATA_W-1:0] read_data;
    logic              write;
    logic              read;

    modport master (output address, wrt_data, write, read, input read_data);
    modport slave  (input address, wrt_data, write, read, output read_data);
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and sequencer in front of the single-ported data_mem.
// One access at a time: IDLE -> ISSUE -> (WAIT) -> RESP, or IDLE -> RESP for rejected accesses.
module dmem_arbiter #(
    parameter int DATA_W    = 64,
    parameter int MEM_BYTES = 1024,
    parameter int READ_LAT  = 1
) (
    input  logic         clk,
    input  logic         reset,
    dmem_port_if.slave   a,
    dmem_port_if.slave   b,
    dmem_bus_if.master   mem,
    output logic         busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

    logic [1:0]        state;
    logic              grant;
    logic              last_grant;
    logic              we_q;
    logic              err_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;
    logic [2:0]        wait_cnt;

    // Winner selection: a lone requester wins; on a tie the port not granted last time wins.
    logic              pick_b;
    logic              sel_we;
    logic [DATA_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_err;

    always_comb begin
        pick_b    = b.req && (!a.req || (last_grant == GRANT_A));
        sel_we    = pick_b ? b.we    : a.we;
        sel_addr  = pick_b ? b.addr  : a.addr;
        sel_wdata = pick_b ? b.wdata : a.wdata;
        sel_err   = (sel_addr[2:0] != 3'd0) || (sel_addr >= DATA_W'(MEM_BYTES));
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            grant      <= GRANT_A;
            last_grant <= GRANT_B;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            wait_cnt   <= 3'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (a.req || b.req) begin
                        grant      <= pick_b;
                        last_grant <= pick_b;
                        we_q       <= sel_we;
                        addr_q     <= sel_addr;
                        wdata_q    <= sel_wdata;
                        err_q      <= sel_err;
                        state      <= sel_err ? S_RESP : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (we_q) begin
                        state <= S_RESP;
                    end else begin
                        wait_cnt <= 3'(READ_LAT);
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 3'd1;
                    if (wait_cnt == 3'd1) begin
                        if (grant == GRANT_B) b_rdata_q <= mem.read_data;
                        else                  a_rdata_q <= mem.read_data;
                        state <= S_RESP;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobes and acks decode straight from state so reset clears them immediately.
    assign mem.address  = addr_q;
    assign mem.wrt_data = wdata_q;
    assign mem.write    = (state == S_ISSUE) &&  we_q;
    assign mem.read     = (state == S_ISSUE) && !we_q;

    assign a.ack   = (state == S_RESP) && (grant == GRANT_A);
    assign b.ack   = (state == S_RESP) && (grant == GRANT_B);
    assign a.err   = a.ack && err_q;
    assign b.err   = b.ack && err_q;
    assign a.rdata = a_rdata_q;
    assign b.rdata = b_rdata_q;

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, contention/latency/reset sequences,
// and a randomized run against a transaction-level reference model.
module tb_dmem_arbiter;

    logic clk;
    logic reset;
    logic busy1;
    logic busy2;

    dmem_port_if #(.DATA_W(64)) a_if  ();
    dmem_port_if #(.DATA_W(64)) b_if  ();
    dmem_bus_if  #(.DATA_W(64)) m_if  ();
    dmem_port_if #(.DATA_W(64)) a2_if ();
    dmem_port_if #(.DATA_W(64)) b2_if ();
    dmem_bus_if  #(.DATA_W(64)) m2_if ();

    dmem_arbiter #(.DATA_W(64), .MEM_BYTES(1024), .READ_LAT(1)) dut (
        .clk(clk), .reset(reset), .a(a_if), .b(b_if), .mem(m_if), .busy(busy1)
    );

    dmem_arbiter #(.DATA_W(64), .MEM_BYTES(1024), .READ_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .a(a2_if), .b(b2_if), .mem(m2_if), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] init_word(input int i);
        return 64'hC0DE_0000_0000_0000 | 64'(i);
    endfunction

    // data_mem stand-ins: one read stage for READ_LAT=1, three for READ_LAT=3
    logic [63:0] mem1 [128];
    logic [63:0] mem2 [128];
    logic [63:0] rd1;
    logic [63:0] rd2_p [3];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 128; i++) mem1[i] <= init_word(i);
        end else begin
            if (m_if.write) mem1[m_if.address[9:3]] <= m_if.wrt_data;
            if (m_if.read)  rd1 <= mem1[m_if.address[9:3]];
        end
    end
    assign m_if.read_data = rd1;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 128; i++) mem2[i] <= (i == 1) ? 64'hDEAD : 64'd0;
        end else begin
            if (m2_if.write) mem2[m2_if.address[9:3]] <= m2_if.wrt_data;
            if (m2_if.read)  rd2_p[0] <= mem2[m2_if.address[9:3]];
            rd2_p[1] <= rd2_p[0];
            rd2_p[2] <= rd2_p[1];
        end
    end
    assign m2_if.read_data = rd2_p[2];

    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic [63:0] last_wr_addr;
    logic [63:0] last_wr_data;
    always @(posedge clk) begin
        if (m_if.write) begin
            wr_cnt       = wr_cnt + 1;
            last_wr_addr = m_if.address;
            last_wr_data = m_if.wrt_data;
        end
        if (m_if.read) rd_cnt = rd_cnt + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_ports();
        a_if.req = 0; a_if.we = 0; a_if.addr = '0; a_if.wdata = '0;
        b_if.req = 0; b_if.we = 0; b_if.addr = '0; b_if.wdata = '0;
        a2_if.req = 0; a2_if.we = 0; a2_if.addr = '0; a2_if.wdata = '0;
        b2_if.req = 0; b2_if.we = 0; b2_if.addr = '0; b2_if.wdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One transaction on dut; lat counts edges from the req-sampling edge to the ack-sampling edge.
    task automatic run_txn(input logic pb, input logic we, input logic [63:0] addr,
                           input logic [63:0] wdata, output int lat, output logic err,
                           output logic [63:0] rdata);
        lat = 0; err = 1'bx; rdata = 'x;
        @(negedge clk);
        if (pb) begin b_if.req = 1; b_if.we = we; b_if.addr = addr; b_if.wdata = wdata; end
        else    begin a_if.req = 1; a_if.we = we; a_if.addr = addr; a_if.wdata = wdata; end
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (pb ? b_if.ack : a_if.ack) begin
                lat   = k;
                err   = pb ? b_if.err : a_if.err;
                rdata = pb ? b_if.rdata : a_if.rdata;
                break;
            end
        end
        @(posedge clk);
        #1;
        a_if.req = 0;
        b_if.req = 0;
    endtask

    typedef struct {
        logic        pb;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        exp_err;
        logic [63:0] exp_rdata;
        int          exp_lat;
        int          exp_wr;
        int          exp_rd;
    } vec_t;

    vec_t vecs [11];

    int          order [8];
    logic [63:0] rdat  [8];
    int          n_got;

    // Both ports request together; hold keeps req high after every ack.
    task automatic contend(input int n_acks, input bit hold,
                           input logic [63:0] addr_a, input logic [63:0] addr_b);
        bit drop_a = 0;
        bit drop_b = 0;
        n_got = 0;
        @(negedge clk);
        a_if.req = 1; a_if.we = 0; a_if.addr = addr_a;
        b_if.req = 1; b_if.we = 0; b_if.addr = addr_b;
        for (int k = 0; k < 60 && n_got < n_acks; k++) begin
            @(negedge clk);
            if (drop_a) begin a_if.req = 0; drop_a = 0; end
            if (drop_b) begin b_if.req = 0; drop_b = 0; end
            if (a_if.ack) begin order[n_got] = 0; rdat[n_got] = a_if.rdata; n_got++; drop_a = !hold; end
            if (b_if.ack) begin order[n_got] = 1; rdat[n_got] = b_if.rdata; n_got++; drop_b = !hold; end
        end
        a_if.req = 0;
        b_if.req = 0;
        repeat (6) @(negedge clk);
    endtask

    typedef struct {
        logic        req;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
    } rq_t;

    function automatic rq_t new_req();
        rq_t r;
        int  k;
        k       = $urandom_range(0, 9);
        r.req   = 1'b1;
        r.we    = 1'($urandom_range(0, 1));
        r.wdata = {$urandom, $urandom};
        if (k == 7)      r.addr = 64'($urandom_range(0, 1023)) | 64'd1;
        else if (k == 8) r.addr = 64'(1024 + 8 * $urandom_range(0, 500));
        else if (k == 9) r.addr = 64'(8 * $urandom_range(0, 3));
        else             r.addr = 64'(8 * $urandom_range(0, 127));
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic        err;
        logic [63:0] rdata;
        int          wr0;
        int          rd0;

        reset = 1'b1;
        idle_ports();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("reset_a_ack", a_if.ack, 0);
        check("reset_busy", busy1, 0);
        check("reset_mem_addr", m_if.address, 0);
        check("reset_strobes", {m_if.write, m_if.read}, 0);

        //          pb  we  addr                      wdata     err exp_rdata  lat wr rd
        vecs[0]  = '{0, 1, 64'd0,                    64'd916,    0, 64'd0,      2, 1, 0};
        vecs[1]  = '{0, 0, 64'd0,                    64'd0,      0, 64'd916,    3, 0, 1};
        vecs[2]  = '{0, 1, 64'd8,                    64'h1234,   0, 64'd916,    2, 1, 0};
        vecs[3]  = '{1, 1, 64'd12,                   64'h5555,   1, 64'd0,      1, 0, 0};
        vecs[4]  = '{1, 0, 64'd8,                    64'd0,      0, 64'h1234,   3, 0, 1};
        vecs[5]  = '{0, 0, 64'd1024,                 64'd0,      1, 64'd916,    1, 0, 0};
        vecs[6]  = '{0, 1, 64'd1016,                 64'hABCD,   0, 64'd916,    2, 1, 0};
        vecs[7]  = '{1, 0, 64'd1016,                 64'd0,      0, 64'hABCD,   3, 0, 1};
        vecs[8]  = '{1, 0, 64'd1017,                 64'd0,      1, 64'hABCD,   1, 0, 0};
        vecs[9]  = '{0, 0, 64'hFFFF_FFFF_FFFF_FFF8,  64'd0,      1, 64'd916,    1, 0, 0};
        vecs[10] = '{1, 1, 64'd1024,                 64'h7777,   1, 64'hABCD,   1, 0, 0};

        for (int i = 0; i < 11; i++) begin
            wr0 = wr_cnt;
            rd0 = rd_cnt;
            run_txn(vecs[i].pb, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, err, rdata);
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].exp_lat));
            check($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
            check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_writes", i), 64'(wr_cnt - wr0), 64'(vecs[i].exp_wr));
            check($sformatf("vec%0d_reads", i), 64'(rd_cnt - rd0), 64'(vecs[i].exp_rd));
            if (vecs[i].exp_wr == 1) begin
                check($sformatf("vec%0d_wr_addr", i), last_wr_addr, vecs[i].addr);
                check($sformatf("vec%0d_wr_data", i), last_wr_data, vecs[i].wdata);
            end
        end

        // Contention from reset: A wins the first tie, then B.
        do_reset();
        contend(2, 1'b0, 64'd8, 64'd16);
        check("tie_count", 64'(n_got), 2);
        check("tie_first", 64'(order[0]), 0);
        check("tie_second", 64'(order[1]), 1);
        check("tie_a_rdata", rdat[0], init_word(1));
        check("tie_b_rdata", rdat[1], init_word(2));

        contend(6, 1'b1, 64'd24, 64'd32);
        check("alt_count", 64'(n_got), 6);
        for (int i = 0; i < 6; i++) check($sformatf("alt_grant%0d", i), 64'(order[i]), 64'(i % 2));

        // READ_LAT=3 instance: ack 5 edges after sampling, busy throughout.
        @(negedge clk);
        a2_if.req = 1; a2_if.we = 0; a2_if.addr = 64'd8;
        @(posedge clk);
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check($sformatf("lat3_busy%0d", k), busy2, 1);
            if (a2_if.ack) begin
                lat = k;
                check("lat3_rdata", a2_if.rdata, 64'hDEAD);
                check("lat3_err", a2_if.err, 0);
                break;
            end
        end
        check("lat3_latency", 64'(lat), 5);
        @(posedge clk);
        #1 a2_if.req = 0;
        @(negedge clk);
        check("lat3_idle", busy2, 0);

        // Reset during WAIT abandons the read.
        @(negedge clk);
        a2_if.req = 1; a2_if.we = 0; a2_if.addr = 64'd8;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        check("rst_pre_busy", busy2, 1);
        reset = 1'b1;
        #1;
        check("rst_busy", busy2, 0);
        check("rst_ack", a2_if.ack, 0);
        check("rst_rdata", a2_if.rdata, 0);
        check("rst_addr", m2_if.address, 0);
        check("rst_strobes", {m2_if.write, m2_if.read}, 0);
        a2_if.req = 0;
        @(negedge clk);
        reset = 1'b0;
        begin
            int stray = 0;
            repeat (8) begin
                @(negedge clk);
                if (a2_if.ack || b2_if.ack) stray++;
            end
            check("rst_no_ack", 64'(stray), 0);
        end
        a2_if.req = 1; a2_if.we = 0; a2_if.addr = 64'd8;
        b2_if.req = 1; b2_if.we = 0; b2_if.addr = 64'd16;
        begin
            int first = -1;
            for (int k = 0; k < 20 && first < 0; k++) begin
                @(negedge clk);
                if (a2_if.ack) begin first = 0; check("rst_next_rdata", a2_if.rdata, 64'hDEAD); end
                else if (b2_if.ack) first = 1;
            end
            check("rst_tie_winner", 64'(first), 0);
        end
        a2_if.req = 0;
        b2_if.req = 0;
        repeat (8) @(negedge clk);

        // Randomized traffic against a transaction-level model.
        begin
            logic [63:0] ref_mem [128];
            logic [63:0] m_rdata [2];
            logic [63:0] m_pend;
            rq_t         rq [2];
            rq_t         idle_rq;
            bit          done [2];
            int          m_start;
            int          m_until;
            int          m_vis;
            int          w;
            int          tl;
            logic        m_win;
            logic        m_last;
            logic        m_err;
            logic        m_we;

            do_reset();
            for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);
            idle_rq    = '{1'b0, 1'b0, 64'd0, 64'd0};
            rq[0]      = idle_rq;
            rq[1]      = idle_rq;
            done[0]    = 0;
            done[1]    = 0;
            m_rdata[0] = '0;
            m_rdata[1] = '0;
            m_start    = 0;
            m_until    = 0;
            m_vis      = -1;
            m_win      = 0;
            m_last     = 1;
            m_err      = 0;
            m_we       = 0;
            m_pend     = '0;

            for (int n = 1; n <= 3000; n++) begin
                @(negedge clk);
                if (n > m_until && (rq[0].req || rq[1].req)) begin
                    m_win   = (rq[0].req && rq[1].req) ? !m_last : rq[1].req;
                    m_last  = m_win;
                    w       = int'(m_win);
                    m_we    = rq[w].we;
                    m_err   = (rq[w].addr % 8 != 0) || (rq[w].addr >= 64'd1024);
                    tl      = m_err ? 1 : (m_we ? 2 : 3);
                    m_start = n;
                    m_vis   = n + tl - 1;
                    m_until = n + tl;
                    if (!m_err) begin
                        if (m_we) ref_mem[rq[w].addr / 8] = rq[w].wdata;
                        else      m_pend = ref_mem[rq[w].addr / 8];
                    end
                end

                check("rnd_a_ack", a_if.ack, (n == m_vis) && !m_win);
                check("rnd_b_ack", b_if.ack, (n == m_vis) &&  m_win);
                check("rnd_busy", busy1, (n >= m_start) && (n < m_until));
                check("rnd_strobe_excl", m_if.write && m_if.read, 0);
                if (n == m_vis) begin
                    w = int'(m_win);
                    if (!m_err && !m_we) m_rdata[w] = m_pend;
                    check("rnd_err", m_win ? b_if.err : a_if.err, m_err);
                    check("rnd_rdata", m_win ? b_if.rdata : a_if.rdata, m_rdata[w]);
                end

                for (int p = 0; p < 2; p++) begin
                    if (done[p]) begin
                        done[p] = 0;
                        rq[p]   = ($urandom_range(0, 1) == 1) ? new_req() : idle_rq;
                    end else if (!rq[p].req && $urandom_range(0, 2) == 0) begin
                        rq[p] = new_req();
                    end
                end
                if (n == m_vis) done[int'(m_win)] = 1;

                a_if.req = rq[0].req; a_if.we = rq[0].we; a_if.addr = rq[0].addr; a_if.wdata = rq[0].wdata;
                b_if.req = rq[1].req; b_if.we = rq[1].we; b_if.addr = rq[1].addr; b_if.wdata = rq[1].wdata;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-ported 64-bit data_mem.
- Port A is the core load/store unit; port B is a secondary master such as a DMA or debug loader.
- Grants one access at a time with round-robin fairness, drives data_mem's address, wrt_data, mem_write and mem_read, and waits out the read latency.
- Returns completion to the requester with a one-cycle ack, and rejects misaligned or out-of-range accesses without touching memory.

Parameters:
- DATA_W, 64, data and address width.
- MEM_BYTES, 1024, size of data_mem in bytes; any addr >= MEM_BYTES is out of range.
- READ_LAT, 1, cycles from the mem_read strobe cycle until mem_read_data is valid to sample (legal range 1..7).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- a_req  input  1  port A request; held until a_ack.
- a_we  input  1  port A: 1 = write, 0 = read.
- a_addr  input  DATA_W  port A byte address.
- a_wdata  input  DATA_W  port A write data.
- a_rdata  output  DATA_W  port A read data; valid when a_ack is high.
- a_ack  output  1  port A completion, one-cycle pulse.
- a_err  output  1  port A error flag; qualified by a_ack.
- b_req, b_we, b_addr, b_wdata, b_rdata, b_ack, b_err: same widths and meanings for port B.
- mem_address  output  DATA_W  to data_mem address.
- mem_wrt_data  output  DATA_W  to data_mem wrt_data.
- mem_write  output  1  to data_mem mem_write.
- mem_read  output  1  to data_mem mem_read.
- mem_read_data  input  DATA_W  from data_mem read_data.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE.
  - All strobes, acks and errs = 0.
  - a_rdata, b_rdata, mem_address, mem_wrt_data = 0.
  - last_grant = B, so A wins the first tie.
  - wait counter = 0.
  - Reset mid-transaction abandons the access; no ack is produced.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - On a rising edge with any req high, select the winner. Single requester wins outright; if both are high, the winner is the port not equal to last_grant.
  - Latch the winner's we, addr and wdata into internal registers, then update last_grant.
  - If addr[2:0] != 0 or addr >= MEM_BYTES, go to RESP with err pending. Otherwise go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_address and mem_wrt_data come from the latched registers.
  - mem_write = latched we; mem_read = !latched we.
  - Write goes to RESP. Read goes to WAIT with counter = READ_LAT.
- WAIT:
  - Strobes are 0 and mem_address holds its value.
  - Counter decrements every cycle.
  - On the edge where the counter goes 1→0, sample mem_read_data into the granted port's rdata register and go to RESP.
- RESP (exactly 1 cycle):
  - The granted port's ack = 1 and err = pending error; the other port's ack = 0.
  - Then go to IDLE.
  - rdata holds until that port's next completed read. An erroring read leaves rdata unchanged.
- Latency from the req-sampling edge to the ack cycle:
  - Write: 2 cycles.
  - Read: 2 + READ_LAT cycles.
  - Error: 1 cycle.
- Requester rules:
  - A requester deasserts req or changes fields only at the edge that samples its ack.
  - An IDLE cycle always separates transactions; back-to-back throughput is one access per 3 cycles (write) or 3 + READ_LAT cycles (read).
- Request changes: a req dropped or changed while not granted is ignored; the arbiter re-samples in IDLE.
- Strobe rule: mem_write and mem_read are never high simultaneously, and each is high for at most 1 cycle per transaction.

Test Plan:
- Port A write, then read:
  - A write addr=0, wdata=916 → mem_write pulses 1 cycle with mem_address=0, mem_wrt_data=916; a_ack 2 cycles after req.
  - A read addr=0 → mem_read pulses once; a_ack at cycle 3; a_rdata=916; a_err=0.
- Contention:
  - A and B both request reads of addr 8 and 16 from reset → A served first, then B.
  - Holding both req high continuously → grants alternate A, B, A, B; no port gets two consecutive grants while the other waits.
- Errors:
  - B write addr=12 (misaligned) → b_ack 1 cycle after req with b_err=1; mem_write never asserted; a later read of addr 8 is unchanged.
  - A read addr=1024 → a_err=1; a_rdata keeps its previous value.
- READ_LAT=3: read of addr 8 holding 0xDEAD → a_ack exactly 5 cycles after the req edge; a_rdata=0xDEAD; busy high for those 5 cycles.
- Reset mid-operation: assert reset during WAIT → outputs go to 0 immediately, no ack follows, state returns to IDLE; the next request completes normally with A favoured on a tie.
